fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register; sits directly upstream of the decode stage.
- Drives the instruction-memory read address and splits each fetched instruction into opcode/Rdst/Rsrc1/Rsrc2 fields. These fields feed decode's control-unit and register-file read ports.
- Handles the reset-vector load, two-word (immediate) instructions, stalls and taken-branch redirects.

---
 rtl/fetch_pkg.sv | 42 ++++
 rtl/if_id_reg.sv | 79 +++++++
 rtl/fetch_stage.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg -- shared types and constants for the instruction-fetch stage.
//   state_e     : fetch FSM states (interrupt states only used when the
//                 FETCH_INT_EN build macro is defined)
//   ifid_ctl_e  : IF/ID register update command
//   field positions of the 16-bit instruction word and the two-word flag bit
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        S_VEC_HI,
        S_VEC_LO,
        S_RUN,
        S_IMM,
        S_INT_HI,
        S_INT_LO
    } state_e;

    // HOLD keeps everything, LOAD captures a new instruction, BUBBLE only
    // drops valid, FLUSH drops valid and clears the instruction word.
    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_BUBBLE,
        IFID_FLUSH
    } ifid_ctl_e;

    localparam int OPC_MSB      = 15;
    localparam int OPC_LSB      = 9;
    localparam int RDST_MSB     = 8;
    localparam int RDST_LSB     = 6;
    localparam int RSRC1_MSB    = 5;
    localparam int RSRC1_LSB    = 3;
    localparam int RSRC2_MSB    = 2;
    localparam int RSRC2_LSB    = 0;
    localparam int TWO_WORD_BIT = 15;

    function automatic logic is_two_word(input logic [15:0] word);
        return word[TWO_WORD_BIT];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg -- IF/ID pipeline register.
//   clk_i, rst_i  : clock, synchronous active-high reset (clears everything)
//   ctl_i         : HOLD / LOAD / BUBBLE / FLUSH command from the fetch FSM
//   instr_i, imm_i, pc_i, pc_next_i : values captured on LOAD
//   valid_o, instr_o, imm_o, pc_o, pc_next_o : registered outputs to decode
// -----------------------------------------------------------------------------
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int INST_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  ifid_ctl_e         ctl_i,
    input  logic [INST_W-1:0] instr_i,
    input  logic [INST_W-1:0] imm_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   pc_next_i,
    output logic              valid_o,
    output logic [INST_W-1:0] instr_o,
    output logic [INST_W-1:0] imm_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   pc_next_o
);

    logic              valid_q,   valid_d;
    logic [INST_W-1:0] instr_q,   instr_d;
    logic [INST_W-1:0] imm_q,     imm_d;
    logic [PC_W-1:0]   pc_q,      pc_d;
    logic [PC_W-1:0]   pc_next_q, pc_next_d;

    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        case (ctl_i)
            IFID_LOAD: begin
                valid_d   = 1'b1;
                instr_d   = instr_i;
                imm_d     = imm_i;
                pc_d      = pc_i;
                pc_next_d = pc_next_i;
            end
            IFID_BUBBLE: valid_d = 1'b0;
            IFID_FLUSH: begin
                valid_d = 1'b0;
                instr_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            pc_next_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
        end
    end

    assign valid_o   = valid_q;
    assign instr_o   = instr_q;
    assign imm_o     = imm_q;
    assign pc_o      = pc_q;
    assign pc_next_o = pc_next_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- instruction fetch FSM + PC, feeding the IF/ID register.
//   clk, rst (sync, active high)
//   imem_addr/imem_data : asynchronous-read instruction memory
//   stall               : hold the stage (branch_taken wins over it)
//   branch_taken/branch_target : redirect and flush
//   if_valid, if_instr, if_imm, if_pc, if_pc_next : IF/ID contents
//   opcode, Rdst, Rsrc1, Rsrc2 : field slices of if_instr
// Build macro FETCH_INT_EN adds int_req (in) / int_ret_pc (out) and the
// interrupt-vector load states S_INT_HI / S_INT_LO.
// The PC is assembled from two memory words, so PC_W is expected to be
// 2*INST_W.
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          PC_W           = 32,
    parameter int          INST_W         = 16,
    parameter int unsigned RESET_VEC_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
`ifdef FETCH_INT_EN
    input  logic              int_req,
    output logic [PC_W-1:0]   int_ret_pc,
`endif
    output logic              if_valid,
    output logic [INST_W-1:0] if_instr,
    output logic [INST_W-1:0] if_imm,
    output logic [PC_W-1:0]   if_pc,
    output logic [PC_W-1:0]   if_pc_next,
    output logic [OPC_MSB-OPC_LSB:0]     opcode,
    output logic [RDST_MSB-RDST_LSB:0]   Rdst,
    output logic [RSRC1_MSB-RSRC1_LSB:0] Rsrc1,
    output logic [RSRC2_MSB-RSRC2_LSB:0] Rsrc2
);

    localparam logic [PC_W-1:0] VEC_ADDR = PC_W'(RESET_VEC_ADDR);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    logic [PC_W-1:0]   hold_pc_q, hold_pc_d;
    logic [INST_W-1:0] hold_word_q, hold_word_d;

    ifid_ctl_e         ifid_ctl;
    logic [INST_W-1:0] ld_instr, ld_imm;
    logic [PC_W-1:0]   ld_pc;

`ifdef FETCH_INT_EN
    logic [PC_W-1:0]   int_ret_pc_q, int_ret_pc_d;
    logic              int_pend_q, int_pend_d;
`endif

    assign pc_inc = pc_q + PC_W'(1);   // wraps modulo 2^PC_W

    // Address depends only on state and pc, so a stall keeps it stable.
    always_comb begin
        imem_addr = pc_q;
        case (state_q)
            S_VEC_HI: imem_addr = VEC_ADDR;
            S_VEC_LO: imem_addr = VEC_ADDR + PC_W'(1);
`ifdef FETCH_INT_EN
            S_INT_HI: imem_addr = VEC_ADDR + PC_W'(2);
            S_INT_LO: imem_addr = VEC_ADDR + PC_W'(3);
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_pc_d   = hold_pc_q;
        hold_word_d = hold_word_q;
        ifid_ctl    = IFID_HOLD;
        ld_instr    = imem_data;
        ld_imm      = '0;
        ld_pc       = pc_q;
`ifdef FETCH_INT_EN
        int_ret_pc_d = int_ret_pc_q;
        int_pend_d   = int_pend_q;
`endif
        if (branch_taken) begin
            // Redirect wins over stall and aborts any vector / second-word load.
            pc_d        = branch_target;
            state_d     = S_RUN;
            hold_word_d = '0;
            ifid_ctl    = IFID_FLUSH;
        end else if (!stall) begin
            case (state_q)
                S_VEC_HI: begin
                    pc_d    = {imem_data, pc_q[INST_W-1:0]};
                    state_d = S_VEC_LO;
                end
                S_VEC_LO: begin
                    pc_d    = {pc_q[PC_W-1:INST_W], imem_data};
                    state_d = S_RUN;
                end
                S_RUN: begin
`ifdef FETCH_INT_EN
                    // Word at pc is not consumed; execution resumes there.
                    if (int_req || int_pend_q) begin
                        int_ret_pc_d = pc_q;
                        int_pend_d   = 1'b0;
                        ifid_ctl     = IFID_BUBBLE;
                        state_d      = S_INT_HI;
                    end else
`endif
                    if (is_two_word(imem_data)) begin
                        // Park the first word; IF/ID gets a bubble until
                        // the immediate arrives next cycle.
                        hold_word_d = imem_data;
                        hold_pc_d   = pc_q;
                        pc_d        = pc_inc;
                        ifid_ctl    = IFID_BUBBLE;
                        state_d     = S_IMM;
                    end else begin
                        pc_d     = pc_inc;
                        ifid_ctl = IFID_LOAD;
                    end
                end
                S_IMM: begin
                    ld_instr = hold_word_q;
                    ld_imm   = imem_data;
                    ld_pc    = hold_pc_q;
                    pc_d     = pc_inc;
                    ifid_ctl = IFID_LOAD;
                    state_d  = S_RUN;
`ifdef FETCH_INT_EN
                    if (int_req) int_pend_d = 1'b1;
`endif
                end
`ifdef FETCH_INT_EN
                S_INT_HI: begin
                    pc_d    = {imem_data, pc_q[INST_W-1:0]};
                    state_d = S_INT_LO;
                end
                S_INT_LO: begin
                    pc_d    = {pc_q[PC_W-1:INST_W], imem_data};
                    state_d = S_RUN;
                end
`endif
                default: state_d = S_VEC_HI;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_VEC_HI;
            pc_q        <= '0;
            hold_pc_q   <= '0;
            hold_word_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_word_q <= hold_word_d;
        end
    end

`ifdef FETCH_INT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            int_ret_pc_q <= '0;
            int_pend_q   <= 1'b0;
        end else begin
            int_ret_pc_q <= int_ret_pc_d;
            int_pend_q   <= int_pend_d;
        end
    end
    assign int_ret_pc = int_ret_pc_q;
`endif

    if_id_reg #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_if_id (
        .clk_i     (clk),
        .rst_i     (rst),
        .ctl_i     (ifid_ctl),
        .instr_i   (ld_instr),
        .imm_i     (ld_imm),
        .pc_i      (ld_pc),
        .pc_next_i (pc_inc),
        .valid_o   (if_valid),
        .instr_o   (if_instr),
        .imm_o     (if_imm),
        .pc_o      (if_pc),
        .pc_next_o (if_pc_next)
    );

    assign opcode = if_instr[OPC_MSB:OPC_LSB];
    assign Rdst   = if_instr[RDST_MSB:RDST_LSB];
    assign Rsrc1  = if_instr[RSRC1_MSB:RSRC1_LSB];
    assign Rsrc2  = if_instr[RSRC2_MSB:RSRC2_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        if_valid;
    logic [15:0] if_instr, if_imm;
    logic [31:0] if_pc, if_pc_next;
    logic [6:0]  opcode;
    logic [2:0]  Rdst, Rsrc1, Rsrc2;

    // 256-word memory; high addresses alias onto it (0xFFFFFFFF -> 0xFF)
    logic [15:0] mem [256];
    assign imem_data = mem[imem_addr[7:0]];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_imm        (if_imm),
        .if_pc         (if_pc),
        .if_pc_next    (if_pc_next),
        .opcode        (opcode),
        .Rdst          (Rdst),
        .Rsrc1         (Rsrc1),
        .Rsrc2         (Rsrc2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push(input logic [15:0] i, input logic [15:0] m,
                                 input logic [31:0] p, input logic [31:0] pn);
        exp_t e;
        e.instr = i; e.imm = m; e.pc = p; e.pc_next = pn;
        exp_q.push_back(e);
    endfunction

    // Monitor: a fresh IF/ID load is valid data that was not held by a stall.
    logic edge_stall = 1'b0;
    always @(posedge clk) edge_stall = stall;

    always @(negedge clk) begin
        if (if_valid && !edge_stall) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got instr 0x%0h pc 0x%0h, expected no instruction", if_instr, if_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_instr",   32'(if_instr), 32'(e.instr));
                chk("sb_imm",     32'(if_imm),   32'(e.imm));
                chk("sb_pc",      if_pc,         e.pc);
                chk("sb_pc_next", if_pc_next,    e.pc_next);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},   32'(if_valid),   32'd0);
        chk({tag, "_instr"},   32'(if_instr),   32'd0);
        chk({tag, "_imm"},     32'(if_imm),     32'd0);
        chk({tag, "_pc"},      if_pc,           32'd0);
        chk({tag, "_pc_next"}, if_pc_next,      32'd0);
        chk({tag, "_opcode"},  32'(opcode),     32'd0);
        chk({tag, "_addr"},    imem_addr,       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s_addr, s_pc, s_pcn;
        logic [15:0] s_instr, s_imm;
        logic        s_valid;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0000;   // reset vector hi
        mem[8'h01] = 16'h0010;   // reset vector lo
        mem[8'h10] = 16'h0A53;   // one-word
        mem[8'h11] = 16'h8A40;   // two-word
        mem[8'h12] = 16'h1234;   //   immediate
        mem[8'h13] = 16'h8000;   // two-word, branched away in S_IMM
        mem[8'h14] = 16'hBEEF;
        mem[8'h20] = 16'h9000;   // two-word, reset in S_IMM
        mem[8'h40] = 16'h0E21;   // branch target, one-word
        mem[8'h41] = 16'h8123;   // two-word
        mem[8'h42] = 16'h0042;
        mem[8'hFF] = 16'h0123;   // at 0xFFFFFFFF

        // reset
        repeat (2) tick();
        chk_zero("rst");
        rst = 1'b0;

        // reset-vector load
        tick();
        chk("vec_lo_addr",  imem_addr, 32'h1);
        chk("vec_lo_valid", 32'(if_valid), 32'd0);
        tick();
        chk("first_fetch_addr", imem_addr, 32'h10);
        chk("vec_done_valid",   32'(if_valid), 32'd0);
        push(16'h0A53, 16'h0, 32'h10, 32'h11);

        // one-word instruction
        tick();
        chk("ow_valid",  32'(if_valid), 32'd1);
        chk("ow_opcode", 32'(opcode), 32'h05);
        chk("ow_rdst",   32'(Rdst),   32'd1);
        chk("ow_rsrc1",  32'(Rsrc1),  32'd2);
        chk("ow_rsrc2",  32'(Rsrc2),  32'd3);
        chk("ow_addr",   imem_addr,   32'h11);
        push(16'h8A40, 16'h1234, 32'h11, 32'h13);

        // two-word: bubble, then stall 3 cycles in S_IMM
        tick();
        chk("tw_bubble", 32'(if_valid), 32'd0);
        chk("tw_addr",   imem_addr,     32'h12);
        s_addr = imem_addr; s_valid = if_valid; s_instr = if_instr;
        s_imm = if_imm; s_pc = if_pc; s_pcn = if_pc_next;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_addr",    imem_addr,          s_addr);
            chk("stall_valid",   32'(if_valid),      32'(s_valid));
            chk("stall_instr",   32'(if_instr),      32'(s_instr));
            chk("stall_imm",     32'(if_imm),        32'(s_imm));
            chk("stall_pc",      if_pc,              s_pc);
            chk("stall_pc_next", if_pc_next,         s_pcn);
        end
        stall = 1'b0;
        tick();
        chk("post_stall_addr", imem_addr, 32'h13);

        // two-word at 0x13 -> bubble, then branch+stall while in S_IMM
        tick();
        chk("tw2_bubble", 32'(if_valid), 32'd0);
        chk("tw2_addr",   imem_addr,     32'h14);
        branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h40;
        tick();
        chk("br_valid", 32'(if_valid), 32'd0);
        chk("br_instr", 32'(if_instr), 32'd0);
        chk("br_addr",  imem_addr,     32'h40);
        branch_taken = 1'b0; stall = 1'b0;
        push(16'h0E21, 16'h0, 32'h40, 32'h41);
        push(16'h8123, 16'h0042, 32'h41, 32'h43);
        tick();
        tick();
        chk("br_tw_bubble", 32'(if_valid), 32'd0);
        tick();

        // wrap at 0xFFFFFFFF
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFF);
        branch_taken = 1'b0;
        push(16'h0123, 16'h0, 32'hFFFF_FFFF, 32'h0);
        tick();
        chk("wrap_pc_zero", imem_addr, 32'h0);

        // reset in S_IMM
        branch_taken = 1'b1; branch_target = 32'h20;
        tick();
        chk("br2_addr", imem_addr, 32'h20);
        branch_taken = 1'b0;
        tick();
        chk("imm_state_valid", 32'(if_valid), 32'd0);
        chk("imm_state_addr",  imem_addr,     32'h21);
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        tick();
        tick();
        chk("revec_addr", imem_addr, 32'h10);
        push(16'h0A53, 16'h0, 32'h10, 32'h11);
        push(16'h8A40, 16'h1234, 32'h11, 32'h13);
        repeat (3) tick();
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
